// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: HS/VS/DE from porch/sync parameters,
// look-ahead frame-buffer requests, and per-frame test-pattern modes.
module video_timing_gen #(
    parameter int H_ACTIVE = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_ACTIVE = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int DATA_W   = 16,
    parameter int REQ_LEAD = 2,
    parameter int XY_W     = 11
) (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] solid_color,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_req,
    output logic [XY_W-1:0]   pixel_xpos,
    output logic [XY_W-1:0]   pixel_ypos,
    output logic              video_hs,
    output logic              video_vs,
    output logic              video_de,
    output logic [DATA_W-1:0] video_data,
    output logic              frame_start,
    output logic [15:0]       frame_cnt
);

    localparam int H_TOTAL     = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL     = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int H_W         = $clog2(H_TOTAL);
    localparam int V_W         = $clog2(V_TOTAL);
    localparam int H_ACT_START = H_SYNC + H_BP;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE;
    localparam int V_ACT_START = V_SYNC + V_BP;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE;
    localparam int BAR_W       = (H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8;

    // The look-ahead counters run REQ_LEAD cycles ahead of the raster counters.
    localparam logic [H_W-1:0] LA_H_INIT = H_W'(REQ_LEAD % H_TOTAL);
    localparam logic [V_W-1:0] LA_V_INIT = V_W'((REQ_LEAD / H_TOTAL) % V_TOTAL);

    function automatic logic [15:0] barColor(input int idx);
        case (idx)
            0:       barColor = 16'hFFFF;
            1:       barColor = 16'hFFE0;
            2:       barColor = 16'h07FF;
            3:       barColor = 16'h07E0;
            4:       barColor = 16'hF81F;
            5:       barColor = 16'hF800;
            6:       barColor = 16'h001F;
            default: barColor = 16'h0000;
        endcase
    endfunction

    logic [H_W-1:0]    h_q, h_d, hla_q, hla_d;
    logic [V_W-1:0]    v_q, v_d, vla_q, vla_d;
    logic [1:0]        mode_q, mode_d;
    logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic              req_q, req_d, fs_q, fs_d;
    logic [XY_W-1:0]   xpos_q, xpos_d, ypos_q, ypos_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [15:0]       fcnt_q, fcnt_d;

    always_comb begin
        int  h, v, hl, vl, x, bar;
        logic       frameTop;
        logic [1:0] modeEff;

        h        = int'(h_q);
        v        = int'(v_q);
        hl       = int'(hla_q);
        vl       = int'(vla_q);
        frameTop = (h == 0) && (v == 0);
        modeEff  = frameTop ? mode : mode_q;
        mode_d   = modeEff;

        h_d   = (h == H_TOTAL - 1) ? '0 : H_W'(h + 1);
        v_d   = v_q;
        if (h == H_TOTAL - 1) v_d = (v == V_TOTAL - 1) ? '0 : V_W'(v + 1);
        hla_d = (hl == H_TOTAL - 1) ? '0 : H_W'(hl + 1);
        vla_d = vla_q;
        if (hl == H_TOTAL - 1) vla_d = (vl == V_TOTAL - 1) ? '0 : V_W'(vl + 1);

        hs_d = (h < H_SYNC) ? HS_POL : ~HS_POL;
        vs_d = (v < V_SYNC) ? VS_POL : ~VS_POL;
        de_d = (h >= H_ACT_START) && (h < H_ACT_END) &&
               (v >= V_ACT_START) && (v < V_ACT_END);

        x   = h - H_ACT_START;
        bar = x / BAR_W;
        if (bar > 7) bar = 7;
        data_d = '0;
        if (de_d) begin
            case (modeEff)
                2'd0:    data_d = data_in;
                2'd1:    data_d = DATA_W'(barColor(bar));
                2'd2:    data_d = solid_color;
                default: data_d = DATA_W'(x);
            endcase
        end

        req_d  = (modeEff == 2'd0) &&
                 (hl >= H_ACT_START) && (hl < H_ACT_END) &&
                 (vl >= V_ACT_START) && (vl < V_ACT_END);
        xpos_d = req_d ? XY_W'(hl - H_ACT_START) : '0;
        ypos_d = req_d ? XY_W'(vl - V_ACT_START) : '0;

        fs_d   = frameTop;
        fcnt_d = frameTop ? fcnt_q + 16'd1 : fcnt_q;

        // Idle: restart the raster from the frame origin, keep the frame count.
        if (!enable) begin
            h_d    = '0;
            v_d    = '0;
            hla_d  = LA_H_INIT;
            vla_d  = LA_V_INIT;
            mode_d = mode_q;
            hs_d   = ~HS_POL;
            vs_d   = ~VS_POL;
            de_d   = 1'b0;
            data_d = '0;
            req_d  = 1'b0;
            xpos_d = '0;
            ypos_d = '0;
            fs_d   = 1'b0;
            fcnt_d = fcnt_q;
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_q    <= '0;
            v_q    <= '0;
            hla_q  <= LA_H_INIT;
            vla_q  <= LA_V_INIT;
            mode_q <= 2'd0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            de_q   <= 1'b0;
            req_q  <= 1'b0;
            xpos_q <= '0;
            ypos_q <= '0;
            data_q <= '0;
            fs_q   <= 1'b0;
            fcnt_q <= '0;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            hla_q  <= hla_d;
            vla_q  <= vla_d;
            mode_q <= mode_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            de_q   <= de_d;
            req_q  <= req_d;
            xpos_q <= xpos_d;
            ypos_q <= ypos_d;
            data_q <= data_d;
            fs_q   <= fs_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign data_req    = req_q;
    assign pixel_xpos  = xpos_q;
    assign pixel_ypos  = ypos_q;
    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign video_data  = data_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;

endmodule
